// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 access sizes
// and the default bus timeout.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 15;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: misalignment detect, byte enables, store data
// replication and load lane select/extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            req_funct3_i,
  input  logic [1:0]            req_off_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  req_misaligned_o,
  output logic [3:0]            req_be_o,
  output logic [DATA_WIDTH-1:0] req_wdata_o,
  input  logic [2:0]            ld_funct3_i,
  input  logic [1:0]            ld_off_i,
  input  logic [DATA_WIDTH-1:0] ld_rdata_i,
  output logic [DATA_WIDTH-1:0] ld_data_o
);

  logic [DATA_WIDTH-1:0] ld_shift;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign req_misaligned_o = is_misaligned(req_funct3_i, req_off_i);

  always_comb begin
    req_be_o    = 4'b1111;
    req_wdata_o = req_wdata_i;
    case (req_funct3_i)
      F3_B, F3_BU: begin
        req_be_o    = 4'b0001 << req_off_i;
        req_wdata_o = {(DATA_WIDTH/8){req_wdata_i[7:0]}};
      end
      F3_H, F3_HU: begin
        req_be_o    = 4'b0011 << req_off_i;
        req_wdata_o = {(DATA_WIDTH/16){req_wdata_i[15:0]}};
      end
      default: begin
        req_be_o    = 4'b1111;
        req_wdata_o = req_wdata_i;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
  assign ld_byte  = ld_shift[7:0];
  assign ld_half  = ld_shift[15:0];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_H:    ld_data_o = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: runs one bus transaction per aligned access,
// stalls the pipeline until the response arrives, and flags misalignment/timeouts.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [2:0]            i_funct3_M,
  input  logic [DATA_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_wdata_M,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [DATA_WIDTH-1:0] o_bus_addr,
  output logic [3:0]            o_bus_be,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  input  logic                  i_bus_gnt,
  input  logic                  i_bus_rvalid,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  output logic                  o_stall_M,
  output logic                  o_flush_WB,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_misaligned,
  output logic                  o_bus_err
);

  lsu_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic [2:0]            funct3_q;
  logic                  we_q;

  logic                  access;
  logic                  misaligned;
  logic                  launch;
  logic                  timeout_hit;
  logic [3:0]            req_be;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign access      = i_mem_read_M | i_mem_write_M;
  assign launch      = (state_q == ST_IDLE) && access && !misaligned;
  assign timeout_hit = (cnt_q >= 4'(TIMEOUT - 1));

  lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .req_funct3_i    (i_funct3_M),
    .req_off_i       (i_addr_M[1:0]),
    .req_wdata_i     (i_wdata_M),
    .req_misaligned_o(misaligned),
    .req_be_o        (req_be),
    .req_wdata_o     (req_wdata),
    .ld_funct3_i     (funct3_q),
    .ld_off_i        (addr_q[1:0]),
    .ld_rdata_i      (i_bus_rdata),
    .ld_data_o       (ld_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (launch) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end
      end
      // A grant wins over a same-cycle rvalid; the response is only taken in RESP.
      ST_REQ: begin
        cnt_d = cnt_q + 4'd1;
        if (i_bus_gnt) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + 4'd1;
        if (i_bus_rvalid) begin
          state_d = ST_DONE;
          rdata_d = we_q ? '0 : ld_ext;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are latched at launch so the bus sees stable values until grant.
  always_ff @(posedge clk) begin
    if (launch) begin
      addr_q   <= i_addr_M;
      wdata_q  <= req_wdata;
      be_q     <= req_be;
      funct3_q <= i_funct3_M;
      we_q     <= i_mem_write_M;
    end
  end

  assign o_bus_req     = (state_q == ST_REQ);
  assign o_bus_we      = o_bus_req & we_q;
  assign o_bus_addr    = o_bus_req ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
  assign o_bus_be      = o_bus_req ? be_q : 4'b0000;
  assign o_bus_wdata   = o_bus_req ? wdata_q : '0;

  assign o_stall_M     = launch || (state_q == ST_REQ) || (state_q == ST_RESP);
  assign o_misaligned  = (state_q == ST_IDLE) && access && misaligned;
  assign o_bus_err     = (state_q == ST_DONE) && err_q;
  assign o_flush_WB    = o_misaligned || o_bus_err;
  assign o_read_data_M = (state_q == ST_DONE) ? rdata_q : '0;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, datapath width; TIMEOUT, 15, max cycles waiting on bus before error (4-bit counter).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_mem_read_M  in  1  MEM-stage load request.
REQ-005 i_mem_write_M  in  1  MEM-stage store request (never high together with i_mem_read_M).
REQ-006 i_funct3_M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 i_addr_M  in  DATA_WIDTH  byte address (ALU result).
REQ-008 i_wdata_M  in  DATA_WIDTH  store data, right-aligned.
REQ-009 o_bus_req, o_bus_we  out  1 each  bus request and write flag.
REQ-010 o_bus_addr  out  DATA_WIDTH  word-aligned address (addr[1:0] forced 00).
REQ-011 o_bus_be  out  4  byte enables; o_bus_wdata  out  DATA_WIDTH  lane-replicated store data.
REQ-012 i_bus_gnt, i_bus_rvalid  in  1 each  grant and response-valid; i_bus_rdata  in  DATA_WIDTH.
REQ-013 o_stall_M  out  1  freeze PC, IF/ID, ID/EX, EX/MEM registers.
REQ-014 o_flush_WB  out  1  force bubble (reg_write=0) into MEM/WB on next edge.
REQ-015 o_read_data_M  out  DATA_WIDTH  extended load data toward MEM/WB; o_misaligned, o_bus_err  out  1 each  exception flags.

Function
REQ-016 Access = i_mem_read_M | i_mem_write_M; misaligned = (H/HU & addr[0]) | (W & addr[1:0]!=00).
REQ-017 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-018 IDLE: aligned access -> REQ; misaligned or no access -> stay IDLE.
REQ-019 REQ: o_bus_req=1; i_bus_gnt=1 -> RESP; bus outputs SHALL stay stable until grant.
REQ-020 RESP: i_bus_rvalid=1 -> capture rdata, go DONE; stores also wait for rvalid (write ack), rdata ignored.
REQ-021 DONE: o_stall_M=0 for exactly one cycle, o_read_data_M held from registered capture; -> IDLE unconditionally.
REQ-022 o_stall_M SHALL be combinational: 1 in IDLE with aligned access, in REQ, in RESP; else 0.
REQ-023 Minimum load latency: request cycle + grant cycle + rvalid cycle + DONE = 4 cycles when gnt and rvalid arrive on first opportunity.
REQ-024 Grant and rvalid in the same cycle while in REQ SHALL be treated as grant only; rvalid outside RESP SHALL be ignored.
REQ-025 Byte enables: B/BU 0001<<addr[1:0]; H/HU 0011<<addr[1:0]; W 1111; o_bus_be=0 when o_bus_req=0.
REQ-026 Store data: B replicated 4x, H replicated 2x, W unchanged.
REQ-027 Load extension: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-028 Misaligned access: o_misaligned=1 combinationally in that cycle, no bus request, no stall, o_flush_WB=1.
REQ-029 Timeout: 4-bit counter cleared on entry to REQ, increments each cycle in REQ/RESP; reaching TIMEOUT -> o_bus_err pulse 1 cycle, o_read_data_M=0, o_flush_WB=1, go DONE.
REQ-030 o_flush_WB SHALL be 0 in all other cases.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, counter 0, captured data 0; mid-transaction reset abandons the bus access with o_bus_req=0 immediately.
REQ-032 While reset asserted all outputs SHALL be 0 except those combinationally derived from inputs in IDLE (o_stall_M, o_misaligned, o_flush_WB).

Structure
REQ-033 State enum, funct3 size encodings and TIMEOUT default SHALL live in shared package lsu_pkg.
REQ-034 Lane alignment, byte-enable generation and load extension SHALL be one combinational sub-module lsu_align; FSM and counter stay in lsu_ctrl.

Verification
REQ-035 LW addr 0x100, gnt at cycle 1, rvalid at cycle 2 data 0xDEADBEEF -> stall 3 cycles, DONE read_data 0xDEADBEEF, be 1111.
REQ-036 LB addr 0x103, rdata 0x80FFFFFF -> be 1000, read_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x202 wdata 0x0000ABCD -> bus_wdata 0xABCDABCD, be 1100, we=1, stall released after rvalid.
REQ-038 LW addr 0x101 -> o_misaligned=1, o_flush_WB=1, o_bus_req=0, o_stall_M=0.
REQ-039 LW with gnt held low 15 cycles -> o_bus_err pulse, read_data 0, flush_WB=1, state back to IDLE.
REQ-040 rst_n low during RESP -> o_bus_req=0 and o_stall_M=0 same cycle, next access starts from IDLE normally.
